ahb_pattern_writer: RTL and testbench
=====================================

# ahb_pattern_writer

AHB-Lite write master that produces the incrementing-data DMA stream that the transfer verifier checks. On a `start` pulse it snapshots the RCC DMA configuration and writes `RCC_Words_N` 32-bit words to memory as one undefined-length INCR burst. Word k carries `init_data + k` and goes to address `{RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW} + 4k`. It sits between the RCC register block and the AHB-Lite interconnect, on the same bus the verifier monitors.

## Interface
- `ADDR_INCR`, default 4: byte increment between beats.
- `HCLK` in 1: bus clock; all logic runs on the rising edge.
- `HRESETn` in 1: reset; one clock; reset is asynchronous and active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `RCC_Words_N` in 6: number of words to write, 0..63.
- `RCC_DMA_ADDR_HIGH` in 16: upper half of the start byte address.
- `RCC_DMA_ADDR_LOW` in 16: lower half of the start byte address.
- `init_data` in 32: data value for beat 0.
- `HREADY` in 1: slave ready.
- `HRESP` in 1: 0 = OKAY, 1 = ERROR.
- `HTRANS` out 2 (`HTRANS_state`): IDLE=00, NONSEQ=10, SEQ=11. BUSY is never driven.
- `HADDR` out 32: address-phase address.
- `HWRITE` out 1: 1 whenever `HTRANS` != IDLE.
- `HSIZE` out 3: constant 3'b010 (word).
- `HBURST` out 3: 3'b001 (INCR) while busy; 3'b000 otherwise.
- `HWDATA` out 32: data-phase write data.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `error` out 1: sticky; cleared by the next accepted `start`.

## Operation
- Reset values: `HTRANS`=IDLE, `HADDR`=0, `HWRITE`=0, `HBURST`=0, `HWDATA`=0, `busy`=0, `done`=0, `error`=0, FSM=IDLE, counters=0.
- Reset asserted mid-burst aborts immediately and asynchronously. No `done` pulse is generated.
- Accepting `start` in IDLE latches base address, `init_data` and N, and clears `error`.
- If N=0: no bus activity; `done` pulses in the next cycle; `busy` stays 0.
- FSM states:
  - IDLE
  - ADDR: address phases issuing.
  - LAST: final data phase, `HTRANS`=IDLE.
  - ABORT
- ADDR state:
  - Beat 0 is NONSEQ; later beats are SEQ.
  - An address beat advances only on an edge where `HREADY`=1.
  - After beat N-1 is accepted, go to LAST.
- 1 KB boundary: when `HADDR[9:0]` of a beat is 0, that beat is NONSEQ, not SEQ.
- Address arithmetic: `HADDR` = base + `ADDR_INCR`·k, modulo 2^32.
- Data arithmetic: `HWDATA` = `init_data` + k, modulo 2^32.
- LAST state: on `HREADY`=1, go to IDLE and pulse `done`.
- Error handling:
  - `HRESP`=1 with `HREADY`=0 in any data phase → next cycle `HTRANS`=IDLE and go to ABORT.
  - In ABORT, the edge with `HREADY`=1 ends the transfer: `error` is set, `done` pulses, return to IDLE.
  - Remaining beats are discarded.
- `start` while `busy`=1 is ignored. Config inputs changing mid-transfer have no effect.

## Timing
- `start` high at edge 0 → NONSEQ at `HADDR`=base in cycle 1; `busy`=1 from cycle 1.
- The data phase of beat k is the cycle after its address phase is accepted. `HWDATA` is held stable while `HREADY`=0.
- `HADDR`/`HTRANS` are held stable while `HREADY`=0, except on error cancel.
- Zero wait states, N words:
  - Address phases in cycles 1..N.
  - Last data phase in cycle N+1 with `HTRANS`=IDLE.
  - `done`=1 and `busy`=0 in cycle N+2.
- A new `start` is accepted in the `done` cycle. The next burst begins the following cycle.
- Each wait state extends every subsequent phase by exactly one cycle.

## Test plan
- N=4, base 0x2000_0000, `init_data` 0x10, `HREADY`=1 → cycles 1–4 show NONSEQ, SEQ, SEQ, SEQ at 0x2000_0000..0x2000_000C; `HWDATA` 0x10..0x13 in cycles 2–5; `done` pulses in cycle 6.
- Same as above, `HREADY` low for 2 cycles during beat 2's data phase → `HADDR` 0x2000_000C and `HWDATA` 0x12 are held; `done` pulses in cycle 8.
- N=3, base 0x0000_03F8 → beats at 0x3F8 (NONSEQ), 0x3FC (SEQ), 0x400 (NONSEQ).
- N=2, `init_data` 0xFFFF_FFFF, base 0xFFFF_FFFC → data 0xFFFF_FFFF then 0x0; address 0xFFFF_FFFC then 0x0.
- N=5, two-cycle ERROR on beat 1's data phase → `HTRANS`=IDLE in the cycle after the first ERROR cycle; beats 2–4 never issued; `error`=1; one `done` pulse.
- N=0 → `done` in the next cycle with no non-IDLE `HTRANS`. `HRESETn` low during beat 2 of N=8 → all outputs take reset values immediately; a new `start` then runs cleanly.

Source files
------------

// File: rtl/ahb_pattern_writer.sv
// AHB-Lite write master that streams an incrementing data pattern into memory
// as a single undefined-length INCR burst. Word k carries init_data + k and
// goes to the start address + ADDR_INCR*k. A transfer is launched by a start
// pulse and ends with a one-cycle done pulse; an ERROR response cancels the
// rest of the burst and raises a sticky error flag.
module ahb_pattern_writer #(
  parameter int unsigned ADDR_INCR = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [5:0]  RCC_Words_N,
  input  logic [15:0] RCC_DMA_ADDR_HIGH,
  input  logic [15:0] RCC_DMA_ADDR_LOW,
  input  logic [31:0] init_data,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // waiting for start
    S_ADDR  = 2'd1,  // address phases issuing (overlapping previous data phase)
    S_LAST  = 2'd2,  // final data phase, bus address phase idle
    S_ABORT = 2'd3   // second cycle of an ERROR response
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] init_q, init_d;
  logic [5:0]  n_q, n_d;
  logic [5:0]  beat_q, beat_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [31:0] next_addr;
  logic        last_beat;
  logic        err_cancel;

  assign next_addr = haddr_q + ADDR_INCR;
  assign last_beat = (beat_q == n_q - 6'd1);

  // A data phase is open in ADDR once beat 0 has been accepted, and always in
  // LAST. The first ERROR cycle (HREADY low) cancels the pending address phase.
  assign err_cancel = HRESP && !HREADY &&
                      (((state_q == S_ADDR) && (beat_q != 6'd0)) || (state_q == S_LAST));

  // State and datapath registers; reset aborts any burst immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      htrans_q <= TR_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      init_q   <= '0;
      n_q      <= '0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      init_q   <= init_d;
      n_q      <= n_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic of the burst FSM.
  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && (RCC_Words_N != 6'd0)) state_d = S_ADDR;
      S_ADDR: begin
        if (err_cancel)               state_d = S_ABORT;
        else if (HREADY && last_beat) state_d = S_LAST;
      end
      S_LAST: begin
        if (err_cancel)  state_d = S_ABORT;
        else if (HREADY) state_d = S_IDLE;
      end
      S_ABORT: if (HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the bus-facing registers, counters and status flags.
  always_comb begin
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    init_d   = init_q;
    n_d      = n_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    error_d  = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Snapshot configuration; later changes on the inputs are ignored.
          init_d  = init_data;
          n_d     = RCC_Words_N;
          beat_d  = '0;
          error_d = 1'b0;
          if (RCC_Words_N == 6'd0) begin
            done_d = 1'b1;
          end else begin
            htrans_d = TR_NONSEQ;
            haddr_d  = {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW};
          end
        end
      end
      S_ADDR: begin
        if (err_cancel) begin
          htrans_d = TR_IDLE;
        end else if (HREADY) begin
          // Beat k accepted: its data phase starts next cycle.
          hwdata_d = init_q + {26'd0, beat_q};
          if (last_beat) begin
            htrans_d = TR_IDLE;
          end else begin
            haddr_d  = next_addr;
            beat_d   = beat_q + 6'd1;
            // A beat landing on a 1 KB boundary restarts the burst.
            htrans_d = (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
          end
        end
      end
      S_LAST: begin
        if (!err_cancel && HREADY) done_d = 1'b1;
      end
      S_ABORT: begin
        if (HREADY) begin
          error_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign HTRANS = htrans_q;
  assign HADDR  = haddr_q;
  assign HWRITE = (htrans_q != TR_IDLE);
  assign HSIZE  = 3'b010;
  assign busy   = (state_q != S_IDLE);
  assign HBURST = busy ? 3'b001 : 3'b000;
  assign HWDATA = hwdata_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule

// File: tb/tb_ahb_pattern_writer.sv
// Directed bench for ahb_pattern_writer. Cycle n is the interval after the
// n-th rising edge counted from the edge that samples start; outputs are
// sampled 1 ns after each rising edge, inputs are changed at the same point.
module tb_ahb_pattern_writer;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic [5:0]  RCC_Words_N;
  logic [15:0] RCC_DMA_ADDR_HIGH;
  logic [15:0] RCC_DMA_ADDR_LOW;
  logic [31:0] init_data;
  logic        HREADY;
  logic        HRESP;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  ahb_pattern_writer #(.ADDR_INCR(4)) dut (
    .HCLK              (HCLK),
    .HRESETn           (HRESETn),
    .start             (start),
    .RCC_Words_N       (RCC_Words_N),
    .RCC_DMA_ADDR_HIGH (RCC_DMA_ADDR_HIGH),
    .RCC_DMA_ADDR_LOW  (RCC_DMA_ADDR_LOW),
    .init_data         (init_data),
    .HREADY            (HREADY),
    .HRESP             (HRESP),
    .HTRANS            (HTRANS),
    .HADDR             (HADDR),
    .HWRITE            (HWRITE),
    .HSIZE             (HSIZE),
    .HBURST            (HBURST),
    .HWDATA            (HWDATA),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Address-phase view: transfer type, address, and HWRITE following HTRANS.
  task automatic exp_addr(input string tag, input logic [1:0] tr, input logic [31:0] addr);
    check({tag, ".htrans"}, 32'(HTRANS), 32'(tr));
    check({tag, ".hwrite"}, 32'(HWRITE), 32'(tr != T_IDLE));
    if (tr != T_IDLE) check({tag, ".haddr"}, HADDR, addr);
  endtask

  task automatic exp_stat(input string tag, input logic b, input logic d, input logic e);
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".error"}, 32'(error), 32'(e));
  endtask

  // Present a configuration and pulse start; returns in cycle 1. The config
  // inputs are scrambled afterwards, which must not disturb the transfer.
  task automatic launch(input logic [5:0] n, input logic [31:0] base, input logic [31:0] init);
    RCC_Words_N       = n;
    {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW} = base;
    init_data         = init;
    start             = 1'b1;
    tick();
    start             = 1'b0;
    RCC_Words_N       = 6'h2A;
    {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW} = 32'hDEAD_BEE0;
    init_data         = 32'h5A5A_5A5A;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0;
    start = 1'b0;
    RCC_Words_N = '0;
    RCC_DMA_ADDR_HIGH = '0;
    RCC_DMA_ADDR_LOW = '0;
    init_data = '0;
    HREADY = 1'b1;
    HRESP = 1'b0;

    // Reset state.
    tick();
    tick();
    exp_addr("rst", T_IDLE, 32'h0);
    check("rst.haddr",  HADDR, 32'h0);
    check("rst.hwdata", HWDATA, 32'h0);
    check("rst.hburst", 32'(HBURST), 32'h0);
    check("rst.hsize",  32'(HSIZE), 32'h2);
    exp_stat("rst", 1'b0, 1'b0, 1'b0);
    HRESETn = 1'b1;
    tick();
    exp_stat("idle", 1'b0, 1'b0, 1'b0);

    // N=4, zero wait states.
    launch(6'd4, 32'h2000_0000, 32'h10);
    for (int c = 1; c <= 4; c++) begin
      exp_addr($sformatf("t1.c%0d", c), (c == 1) ? T_NSEQ : T_SEQ, 32'h2000_0000 + 32'(4 * (c - 1)));
      if (c >= 2) check($sformatf("t1.c%0d.hwdata", c), HWDATA, 32'h10 + 32'(c - 2));
      exp_stat($sformatf("t1.c%0d", c), 1'b1, 1'b0, 1'b0);
      check($sformatf("t1.c%0d.hburst", c), 32'(HBURST), 32'h1);
      tick();
    end
    exp_addr("t1.c5", T_IDLE, 32'h0);
    check("t1.c5.hwdata", HWDATA, 32'h13);
    exp_stat("t1.c5", 1'b1, 1'b0, 1'b0);
    tick();
    exp_stat("t1.c6", 1'b0, 1'b1, 1'b0);
    check("t1.c6.hburst", 32'(HBURST), 32'h0);

    // Same burst started in the done cycle, with 2 wait states on beat 2 data.
    launch(6'd4, 32'h2000_0000, 32'h10);
    exp_addr("t2.c1", T_NSEQ, 32'h2000_0000);
    exp_stat("t2.c1", 1'b1, 1'b0, 1'b0);
    tick();
    exp_addr("t2.c2", T_SEQ, 32'h2000_0004);
    check("t2.c2.hwdata", HWDATA, 32'h10);
    tick();
    exp_addr("t2.c3", T_SEQ, 32'h2000_0008);
    check("t2.c3.hwdata", HWDATA, 32'h11);
    tick();
    HREADY = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      exp_addr($sformatf("t2.c%0d", c), T_SEQ, 32'h2000_000C);
      check($sformatf("t2.c%0d.hwdata", c), HWDATA, 32'h12);
      if (c == 5) HREADY = 1'b0;
      if (c == 6) HREADY = 1'b1;
      tick();
    end
    exp_addr("t2.c7", T_IDLE, 32'h0);
    check("t2.c7.hwdata", HWDATA, 32'h13);
    exp_stat("t2.c7", 1'b1, 1'b0, 1'b0);
    tick();
    exp_stat("t2.c8", 1'b0, 1'b1, 1'b0);
    tick();

    // N=3 crossing a 1 KB boundary.
    launch(6'd3, 32'h0000_03F8, 32'h0);
    exp_addr("t3.c1", T_NSEQ, 32'h0000_03F8);
    tick();
    exp_addr("t3.c2", T_SEQ, 32'h0000_03FC);
    tick();
    exp_addr("t3.c3", T_NSEQ, 32'h0000_0400);
    check("t3.c3.hwdata", HWDATA, 32'h1);
    tick();
    exp_addr("t3.c4", T_IDLE, 32'h0);
    check("t3.c4.hwdata", HWDATA, 32'h2);
    tick();
    exp_stat("t3.c5", 1'b0, 1'b1, 1'b0);
    tick();

    // N=2 with address and data wrap-around.
    launch(6'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    exp_addr("t4.c1", T_NSEQ, 32'hFFFF_FFFC);
    tick();
    exp_addr("t4.c2", T_NSEQ, 32'h0000_0000);
    check("t4.c2.hwdata", HWDATA, 32'hFFFF_FFFF);
    tick();
    exp_addr("t4.c3", T_IDLE, 32'h0);
    check("t4.c3.hwdata", HWDATA, 32'h0);
    tick();
    exp_stat("t4.c4", 1'b0, 1'b1, 1'b0);
    tick();

    // N=5, two-cycle ERROR on beat 1 data phase.
    launch(6'd5, 32'h0000_1000, 32'h100);
    exp_addr("t5.c1", T_NSEQ, 32'h0000_1000);
    tick();
    exp_addr("t5.c2", T_SEQ, 32'h0000_1004);
    check("t5.c2.hwdata", HWDATA, 32'h100);
    tick();
    exp_addr("t5.c3", T_SEQ, 32'h0000_1008);
    check("t5.c3.hwdata", HWDATA, 32'h101);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    exp_addr("t5.c4", T_IDLE, 32'h0);
    exp_stat("t5.c4", 1'b1, 1'b0, 1'b0);
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    exp_addr("t5.c5", T_IDLE, 32'h0);
    exp_stat("t5.c5", 1'b0, 1'b1, 1'b1);
    tick();
    exp_addr("t5.c6", T_IDLE, 32'h0);
    exp_stat("t5.c6", 1'b0, 1'b0, 1'b1);

    // N=0: done next cycle, no bus activity, error cleared by the start.
    launch(6'd0, 32'h0000_2000, 32'h0);
    exp_addr("t6.c1", T_IDLE, 32'h0);
    exp_stat("t6.c1", 1'b0, 1'b1, 1'b0);
    tick();
    exp_addr("t6.c2", T_IDLE, 32'h0);
    exp_stat("t6.c2", 1'b0, 1'b0, 1'b0);

    // N=8 with asynchronous reset during beat 2.
    launch(6'd8, 32'h0000_4000, 32'h55);
    tick();
    tick();
    exp_addr("t7.c3", T_SEQ, 32'h0000_4008);
    HRESETn = 1'b0;
    #1;
    exp_addr("t7.rst", T_IDLE, 32'h0);
    check("t7.rst.haddr",  HADDR, 32'h0);
    check("t7.rst.hwdata", HWDATA, 32'h0);
    check("t7.rst.hburst", 32'(HBURST), 32'h0);
    exp_stat("t7.rst", 1'b0, 1'b0, 1'b0);
    tick();
    exp_stat("t7.rst2", 1'b0, 1'b0, 1'b0);
    HRESETn = 1'b1;
    tick();

    // Clean run after reset, done awaited with a bounded wait.
    launch(6'd2, 32'h0000_8000, 32'h7);
    exp_addr("t8.c1", T_NSEQ, 32'h0000_8000);
    tick();
    exp_addr("t8.c2", T_SEQ, 32'h0000_8004);
    check("t8.c2.hwdata", HWDATA, 32'h7);
    tick();
    exp_addr("t8.c3", T_IDLE, 32'h0);
    check("t8.c3.hwdata", HWDATA, 32'h8);
    begin
      int waited;
      waited = 0;
      while (!done && waited < 10) begin
        tick();
        waited++;
      end
      check("t8.done_latency", 32'(waited), 32'h1);
      exp_stat("t8.done", 1'b0, 1'b1, 1'b0);
    end
    tick();
    exp_stat("t8.after", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
